// File: rtl/alp_cmd_sequencer.sv
// alp_cmd_sequencer: plays a 16-entry command program onto the ALP command inputs.
module alp_cmd_sequencer #(
  parameter int COMP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_WR_EN,
  input  logic [3:0] i_WR_ADDR,
  input  logic [9:0] i_WR_DATA,
  input  logic       i_START,
  input  logic [3:0] i_LAST,
  input  logic       i_ERR,
  output logic [3:0] o_DATA_IN,
  output logic [2:0] o_OP,
  output logic       o_CLR,
  output logic       o_LOAD,
  output logic       o_COMP,
  output logic       o_BUSY,
  output logic       o_DONE,
  output logic [3:0] o_PC,
  output logic [3:0] o_ERR_CNT,
  output logic       o_BAD_CMD
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, ISSUE = 3'd2, HOLD = 3'd3, FINISH = 3'd4;
  logic [9:0] mem [16];
  logic [2:0] state_q, state_d, hold_q, hold_d;
  logic [3:0] pc_q, pc_d, last_q, last_d, err_cnt_q, err_cnt_d;
  logic [9:0] word_q, word_d;
  logic       bad_q, bad_d, err_chk_q, err_chk_d;
  logic       multi, drive, advance;
  always_ff @(posedge clk)
    if (i_WR_EN && state_q == IDLE) mem[i_WR_ADDR] <= i_WR_DATA;
  always_comb begin
    multi   = (word_q[2] & word_q[1]) | (word_q[2] & word_q[0]) | (word_q[1] & word_q[0]);
    drive   = (state_q == ISSUE && !multi) || state_q == HOLD;
    advance = (state_q == ISSUE && (multi || !word_q[0] || COMP_CYCLES == 1)) ||
              (state_q == HOLD && hold_q == 3'd1);
    state_d   = state_q;
    hold_d    = hold_q;
    pc_d      = pc_q;
    last_d    = last_q;
    word_d    = word_q;
    bad_d     = bad_q;
    err_chk_d = 1'b0;
    // ERR is judged on the cycle right after a compute window closes
    err_cnt_d = (err_chk_q && i_ERR && err_cnt_q != 4'hf) ? err_cnt_q + 4'd1 : err_cnt_q;
    if (state_q == IDLE && i_START) begin
      last_d    = i_LAST;
      pc_d      = 4'd0;
      err_cnt_d = 4'd0;
      bad_d     = 1'b0;
      state_d   = FETCH;
    end
    if (state_q == FETCH) begin
      word_d  = mem[pc_q];
      state_d = ISSUE;
    end
    if (state_q == ISSUE && multi) bad_d = 1'b1;
    if (state_q == ISSUE && !multi && word_q[0] && COMP_CYCLES > 1) begin
      hold_d  = 3'(COMP_CYCLES - 1);
      state_d = HOLD;
    end
    if (state_q == HOLD) hold_d = hold_q - 3'd1;
    if (advance) begin
      state_d   = (pc_q == last_q) ? FINISH : FETCH;
      pc_d      = (pc_q == last_q) ? pc_q : pc_q + 4'd1;
      err_chk_d = word_q[0] && !multi;
    end
    if (state_q == FINISH) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= 3'd0;
      pc_q      <= 4'd0;
      last_q    <= 4'd0;
      word_q    <= 10'd0;
      bad_q     <= 1'b0;
      err_chk_q <= 1'b0;
      err_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      word_q    <= word_d;
      bad_q     <= bad_d;
      err_chk_q <= err_chk_d;
      err_cnt_q <= err_cnt_d;
    end
  assign o_DATA_IN = drive ? word_q[9:6] : 4'd0;
  assign o_OP      = drive ? word_q[5:3] : 3'd0;
  assign o_CLR     = drive & word_q[2];
  assign o_LOAD    = drive & word_q[1];
  assign o_COMP    = drive & word_q[0];
  assign o_BUSY    = state_q == FETCH || state_q == ISSUE || state_q == HOLD;
  assign o_DONE    = state_q == FINISH;
  assign o_PC      = pc_q;
  assign o_ERR_CNT = err_cnt_q;
  assign o_BAD_CMD = bad_q;
endmodule

// File: tb/tb_alp_cmd_sequencer.sv
// tb_alp_cmd_sequencer: directed programs; expected per-cycle outputs queued, checked by a monitor.
module tb_alp_cmd_sequencer;
  localparam int CC = 2;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_WR_EN = 1'b0, i_START = 1'b0, i_ERR = 1'b0;
  logic [3:0] i_WR_ADDR = 4'd0, i_LAST = 4'd0;
  logic [9:0] i_WR_DATA = 10'd0;
  logic [3:0] o_DATA_IN, o_PC, o_ERR_CNT;
  logic [2:0] o_OP;
  logic       o_CLR, o_LOAD, o_COMP, o_BUSY, o_DONE, o_BAD_CMD;
  logic [9:0] pm [16];
  logic [15:0] sb [$];
  int total = 0, nbad = 0;

  alp_cmd_sequencer #(.COMP_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .i_WR_EN(i_WR_EN), .i_WR_ADDR(i_WR_ADDR), .i_WR_DATA(i_WR_DATA),
    .i_START(i_START), .i_LAST(i_LAST), .i_ERR(i_ERR), .o_DATA_IN(o_DATA_IN), .o_OP(o_OP),
    .o_CLR(o_CLR), .o_LOAD(o_LOAD), .o_COMP(o_COMP), .o_BUSY(o_BUSY), .o_DONE(o_DONE),
    .o_PC(o_PC), .o_ERR_CNT(o_ERR_CNT), .o_BAD_CMD(o_BAD_CMD));

  always #5 clk = ~clk;

  function automatic logic [9:0] w(input int d, input int op, input bit c, input bit l, input bit p);
    return {4'(d), 3'(op), c, l, p};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // record: {pc, busy, done, data, op, clr, load, comp}
  always @(negedge clk)
    if (reset && (o_BUSY || o_DONE)) begin
      logic [15:0] act, exp;
      act = {o_PC, o_BUSY, o_DONE, o_DATA_IN, o_OP, o_CLR, o_LOAD, o_COMP};
      total++;
      if (sb.size() == 0) begin
        nbad++;
        $display("FAIL sb_unexpected got=%h want=none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          nbad++;
          $display("FAIL sb_cycle got=%h want=%h", act, exp);
        end
      end
    end

  task automatic push_prog(input logic [3:0] last);
    logic [9:0] x;
    for (int p = 0; p <= int'(last); p++) begin
      x = pm[p];
      sb.push_back({4'(p), 2'b10, 10'd0});
      if ($countones(x[2:0]) >= 2) sb.push_back({4'(p), 2'b10, 10'd0});
      else repeat (x[0] ? CC : 1) sb.push_back({4'(p), 2'b10, x});
    end
    sb.push_back({last, 2'b01, 10'd0});
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    i_WR_EN = 1'b1; i_WR_ADDR = a; i_WR_DATA = d;
    @(negedge clk);
    i_WR_EN = 1'b0;
    pm[a] = d;
  endtask

  task automatic play(input logic [3:0] last, input int exp_cyc, input int exp_err,
                      input bit exp_bad, input bit poke);
    int k;
    push_prog(last);
    i_START = 1'b1; i_LAST = last;
    @(posedge clk);
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      i_START = 1'b0; i_WR_EN = 1'b0;
      if (poke && k == 3) begin
        i_WR_EN = 1'b1; i_WR_ADDR = 4'd0; i_WR_DATA = w(0, 0, 1, 0, 0);
        i_START = 1'b1; i_LAST = 4'd0;
      end
      if (o_DONE) break;
    end
    chk("done_cycle", k, exp_cyc);
    @(negedge clk);
    chk("err_cnt", int'(o_ERR_CNT), exp_err);
    chk("bad_cmd", int'(o_BAD_CMD), int'(exp_bad));
    chk("idle_busy", int'(o_BUSY), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", int'(o_BUSY), 0);
    chk("rst_done", int'(o_DONE), 0);
    chk("rst_pc", int'(o_PC), 0);
    chk("rst_err", int'(o_ERR_CNT), 0);
    chk("rst_drive", int'({o_DATA_IN, o_OP, o_CLR, o_LOAD, o_COMP}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr(0, w(6, 0, 0, 1, 0));
    wr(1, w(9, 0, 0, 1, 0));
    wr(2, w(0, 1, 0, 0, 1));
    play(2, 8, 0, 0, 0);
    i_WR_EN = 1'b1; i_WR_ADDR = 4'd0; i_WR_DATA = w(15, 0, 0, 1, 0);
    pm[0] = w(15, 0, 0, 1, 0);
    play(0, 3, 0, 0, 0);
    wr(0, w(3, 2, 0, 0, 1));
    i_ERR = 1'b1;
    play(0, 4, 1, 0, 0);
    wr(0, w(1, 0, 0, 1, 0));
    wr(1, w(2, 0, 1, 1, 0));
    wr(2, w(7, 4, 0, 0, 0));
    play(2, 7, 0, 1, 0);
    for (int i = 0; i < 16; i++) wr(4'(i), w(i, i % 8, 0, 0, 1));
    play(15, 49, 15, 0, 0);
    i_ERR = 1'b0;
    play(15, 49, 0, 0, 1);
    play(0, 4, 0, 0, 0);
    wr(0, w(4, 0, 0, 1, 0));
    wr(1, w(5, 3, 0, 0, 1));
    push_prog(1);
    i_START = 1'b1; i_LAST = 4'd1;
    @(posedge clk);
    @(negedge clk);
    i_START = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("hold_comp", int'(o_COMP), 1);
    chk("hold_pc", int'(o_PC), 1);
    reset = 1'b0;
    #1;
    chk("arst_drive", int'({o_DATA_IN, o_OP, o_CLR, o_LOAD, o_COMP}), 0);
    chk("arst_busy", int'(o_BUSY), 0);
    chk("arst_pc", int'(o_PC), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    play(1, 6, 0, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule
